// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared pipeline widths, queue entry layout and PC helper
package if_fetch_queue_pkg;
  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int ENTRY_W = XLEN + ILEN;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } fq_entry_t;
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: instruction memory bus plus ID dequeue handshake
interface if_fetch_queue_if
  import if_fetch_queue_pkg::*;
  ;
  logic [XLEN-1:0] iad;
  logic            ireq;
  logic [ILEN-1:0] idt;
  logic            acki_n;
  logic            deq_ready;
  logic            deq_valid;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_pc4;
  logic [ILEN-1:0] deq_ir;
  modport master (
    output iad, ireq, deq_valid, deq_pc, deq_pc4, deq_ir,
    input  idt, acki_n, deq_ready
  );
  modport slave (
    input  iad, ireq, deq_valid, deq_pc, deq_pc4, deq_ir,
    output idt, acki_n, deq_ready
  );
endinterface

// File: rtl/if_fetch_queue_sync_fifo_ptr.sv
// sync_fifo_ptr: generic power-of-two circular buffer with single-cycle clear
module sync_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  assign full    = count_q == FULL_CNT;
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr      = wr_en && !full && !clr;
  assign rd      = rd_en && !empty && !clr;
  // next pointer/occupancy; clear wins over any same-cycle read or write
  always_comb begin
    wr_ptr_d = clr ? '0 : wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = clr ? '0 : rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = clr ? '0 : count_q + CW'(wr) - CW'(rd);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // entry storage needs no reset; occupancy decides what is meaningful
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: prefetch FIFO front end with redirect flush and optional bypass
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter bit              BYPASS   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_queue_if.master       bus,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count
);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  fq_entry_t head, wr_entry;
  logic full, empty, fetch_hit, q_valid, byp_valid, byp_take, enq, deq_q;
  sync_fifo_ptr #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (redirect),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq_q),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  assign bus.iad  = fetch_pc_q;
  assign bus.ireq = !full && !redirect;
  assign wr_entry = '{pc: fetch_pc_q, ir: bus.idt};
  // handshake decode and dequeue mux; redirect masks both queue and bypass
  always_comb begin
    fetch_hit     = bus.ireq && !bus.acki_n;
    q_valid       = !empty && !redirect;
    byp_valid     = BYPASS && empty && fetch_hit;
    byp_take      = byp_valid && bus.deq_ready;
    enq           = fetch_hit && !byp_take;
    deq_q         = q_valid && bus.deq_ready;
    bus.deq_valid = q_valid || byp_valid;
    bus.deq_pc    = q_valid ? head.pc : fetch_pc_q;
    bus.deq_ir    = q_valid ? head.ir : bus.idt;
    bus.deq_pc4   = pc_plus4(bus.deq_pc);
    fetch_pc_d    = redirect ? redirect_pc : fetch_hit ? pc_plus4(fetch_pc_q) : fetch_pc_q;
  end
  // fetch address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_pc_q <= RESET_PC;
    else fetch_pc_q <= fetch_pc_d;
  end
endmodule
